// File: rtl/reg_writeback.sv
// Writeback stage: merges load and ALU results onto the register-file write port and tracks pending writes.
// Optional feature macro REG_WRITEBACK_BYPASS_EN: an ALU result may skip an empty FIFO when no load competes.
module reg_writeback #(
  parameter int WIDTH        = 64,
  parameter int COUNT        = 16,
  parameter int COUNTP       = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [COUNTP-1:0] issue_addr,
  input  logic              issue_super,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [COUNTP-1:0] alu_addr,
  input  logic              alu_super,
  input  logic [WIDTH-1:0]  alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [COUNTP-1:0] mem_addr,
  input  logic              mem_super,
  input  logic [WIDTH-1:0]  mem_data,
  output logic              write_en,
  output logic [COUNTP-1:0] write_addr,
  output logic [WIDTH-1:0]  write_data,
  output logic              supervisor,
  output logic [COUNT-1:0]  busy,
  output logic              ssp_busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [PW:0]       FIFO_FULL  = (PW+1)'(FIFO_DEPTH);
  localparam logic [SW-1:0]     STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [COUNTP-1:0] SSP_REG    = COUNTP'(15);

  typedef struct packed {
    logic [COUNTP-1:0] addr;
    logic              sup;
    logic [WIDTH-1:0]  data;
  } entry_t;

  entry_t            fifo_q [FIFO_DEPTH];
  entry_t            fifo_d [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              write_en_q, write_en_d;
  logic [COUNTP-1:0] write_addr_q, write_addr_d;
  logic [WIDTH-1:0]  write_data_q, write_data_d;
  logic              supervisor_q, supervisor_d;
  logic [COUNT-1:0]  busy_q, busy_d;
  logic              ssp_busy_q, ssp_busy_d;

  logic              fifo_empty, fifo_full;
  logic              alu_turn, load_win, bypass, push, pop;
  logic              issue_ssp, write_ssp;
  logic [COUNT-1:0]  busy_set, busy_clr;
  entry_t            head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FIFO_FULL);
  assign alu_turn   = !fifo_empty && ((starve_q == STARVE_MAX) || !mem_valid);
  assign load_win   = mem_valid && !alu_turn;
  assign alu_ready  = !fifo_full;
  assign mem_ready  = !alu_turn;
  assign head       = fifo_q[rd_ptr_q];

`ifdef REG_WRITEBACK_BYPASS_EN
  assign bypass = alu_valid && fifo_empty && !mem_valid;
`else
  assign bypass = 1'b0;
`endif

  assign push = alu_valid && !fifo_full && !bypass;
  assign pop  = alu_turn;

  // Write port: queued ALU result when it is its turn, else a load, else (optionally) a bypassed ALU result.
  always_comb begin
    write_en_d   = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    supervisor_d = supervisor_q;
    if (pop) begin
      write_en_d   = 1'b1;
      write_addr_d = head.addr;
      write_data_d = head.data;
      supervisor_d = head.sup;
    end else if (load_win) begin
      write_en_d   = 1'b1;
      write_addr_d = mem_addr;
      write_data_d = mem_data;
      supervisor_d = mem_super;
    end else if (bypass) begin
      write_en_d   = 1'b1;
      write_addr_d = alu_addr;
      write_data_d = alu_data;
      supervisor_d = alu_super;
    end
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = '{addr: alu_addr, sup: alu_super, data: alu_data};
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Counts consecutive load wins over a waiting ALU result so the FIFO cannot starve.
  always_comb begin
    starve_d = starve_q;
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (load_win && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // r15 in supervisor mode maps to the SSP bit; a same-edge set overrides the clear.
  always_comb begin
    issue_ssp = issue_super && (issue_addr == SSP_REG);
    write_ssp = supervisor_q && (write_addr_q == SSP_REG);
    busy_set  = '0;
    busy_clr  = '0;
    if (issue_valid && !issue_ssp) begin
      busy_set[issue_addr] = 1'b1;
    end
    if (write_en_q && !write_ssp) begin
      busy_clr[write_addr_q] = 1'b1;
    end
    busy_d     = (busy_q & ~busy_clr) | busy_set;
    ssp_busy_d = (issue_valid && issue_ssp) || (ssp_busy_q && !(write_en_q && write_ssp));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      supervisor_q <= 1'b0;
      busy_q       <= '0;
      ssp_busy_q   <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      supervisor_q <= supervisor_d;
      busy_q       <= busy_d;
      ssp_busy_q   <= ssp_busy_d;
    end
  end

  // Entry storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign write_en   = write_en_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign supervisor = supervisor_q;
  assign busy       = busy_q;
  assign ssp_busy   = ssp_busy_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed vector table, hand-written corner sequences and a
// randomized run against a queue-based reference model. Honours REG_WRITEBACK_BYPASS_EN if defined.
module tb_reg_writeback;

  localparam int WIDTH = 64;
  localparam int COUNT = 16;
  localparam int DEPTH = 4;
  localparam int LIMIT = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             issue_valid, issue_super;
  logic [3:0]       issue_addr;
  logic             alu_valid, alu_ready, alu_super;
  logic [3:0]       alu_addr;
  logic [63:0]      alu_data;
  logic             mem_valid, mem_ready, mem_super;
  logic [3:0]       mem_addr;
  logic [63:0]      mem_data;
  logic             write_en, supervisor, ssp_busy;
  logic [3:0]       write_addr;
  logic [63:0]      write_data;
  logic [15:0]      busy;

  always #5 clk = ~clk;

  reg_writeback #(
    .WIDTH(WIDTH), .COUNT(COUNT), .COUNTP(4), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_super(issue_super),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr),
    .alu_super(alu_super), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_super(mem_super), .mem_data(mem_data),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .supervisor(supervisor), .busy(busy), .ssp_busy(ssp_busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: pending ALU results in arrival order, starvation count, expected outputs.
  typedef struct {
    logic [3:0]  addr;
    logic        sup;
    logic [63:0] data;
  } ent_t;

  ent_t        mq[$];
  int          m_starve;
  logic        m_we, m_sup, m_ssp;
  logic [3:0]  m_addr;
  logic [63:0] m_data;
  logic [15:0] m_busy;
  logic        exp_alu_ready, exp_mem_ready;
  logic        seen_alu_ready, seen_mem_ready;
  logic        alu_acc, mem_acc;

  typedef struct {
    logic        iv;
    logic [3:0]  ia;
    logic        is;
    logic        mv;
    logic [3:0]  ma;
    logic        ms;
    logic [63:0] md;
    logic        e_mr;
    logic        e_we;
    logic [3:0]  e_addr;
    logic [63:0] e_data;
    logic        e_sup;
    logic [15:0] e_busy;
    logic        e_ssp;
  } vec_t;

  vec_t vt[13];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic isSsp(input logic s, input logic [3:0] a);
    return s && (a == 4'd15);
  endfunction

  function automatic logic [3:0] rndAddr();
    return ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
  endfunction

  task automatic idleInputs();
    issue_valid = 1'b0; issue_addr = 4'd0; issue_super = 1'b0;
    alu_valid = 1'b0; alu_addr = 4'd0; alu_super = 1'b0; alu_data = 64'd0;
    mem_valid = 1'b0; mem_addr = 4'd0; mem_super = 1'b0; mem_data = 64'd0;
  endtask

  task automatic modelReset();
    mq.delete();
    m_starve = 0;
    m_we = 1'b0; m_addr = 4'd0; m_data = 64'd0; m_sup = 1'b0;
    m_busy = 16'd0; m_ssp = 1'b0;
    alu_acc = 1'b0; mem_acc = 1'b0;
  endtask

  // One cycle of the writeback rules applied to the inputs currently driven.
  task automatic modelStep();
    int   n = mq.size();
    logic turn, byp, wv;
    ent_t w;
    turn = (n > 0) && ((m_starve == LIMIT) || !mem_valid);
    exp_alu_ready = (n < DEPTH);
    exp_mem_ready = !turn;
    byp = 1'b0;
`ifdef REG_WRITEBACK_BYPASS_EN
    byp = alu_valid && (n == 0) && !mem_valid;
`endif
    alu_acc = alu_valid && exp_alu_ready;
    mem_acc = mem_valid && !turn;
    wv = 1'b1;
    if (turn) w = mq.pop_front();
    else if (mem_valid) w = '{mem_addr, mem_super, mem_data};
    else if (byp) w = '{alu_addr, alu_super, alu_data};
    else wv = 1'b0;
    if (alu_acc && !byp) mq.push_back('{alu_addr, alu_super, alu_data});
    if (turn || n == 0) m_starve = 0;
    else if (mem_valid && m_starve < LIMIT) m_starve++;
    if (m_we) begin
      if (isSsp(m_sup, m_addr)) m_ssp = 1'b0;
      else m_busy[m_addr] = 1'b0;
    end
    if (issue_valid) begin
      if (isSsp(issue_super, issue_addr)) m_ssp = 1'b1;
      else m_busy[issue_addr] = 1'b1;
    end
    m_we = wv;
    if (wv) begin
      m_addr = w.addr; m_sup = w.sup; m_data = w.data;
    end
  endtask

  // Drive one clock with the current inputs; checks handshakes before the edge, registers after it.
  task automatic applyStimulus();
    #1;
    seen_alu_ready = alu_ready;
    seen_mem_ready = mem_ready;
    if (rst) begin
      modelReset();
    end else begin
      modelStep();
      checkOutput("alu_ready", 64'(alu_ready), 64'(exp_alu_ready));
      checkOutput("mem_ready", 64'(mem_ready), 64'(exp_mem_ready));
    end
    @(posedge clk);
    #1;
    checkOutput("write_en", 64'(write_en), 64'(m_we));
    if (m_we) begin
      checkOutput("write_addr", 64'(write_addr), 64'(m_addr));
      checkOutput("write_data", write_data, m_data);
      checkOutput("supervisor", 64'(supervisor), 64'(m_sup));
    end
    checkOutput("busy", 64'(busy), 64'(m_busy));
    checkOutput("ssp_busy", 64'(ssp_busy), 64'(m_ssp));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int low_cnt;

    vt[0]  = '{1'b1,4'd3,1'b0,  1'b0,4'd0,1'b0,64'h0,      1'b1,1'b0,4'd0,64'h0,1'b0,     16'h0008,1'b0};
    vt[1]  = '{1'b0,4'd0,1'b0,  1'b1,4'd3,1'b0,64'h1234,   1'b1,1'b1,4'd3,64'h1234,1'b0,  16'h0008,1'b0};
    vt[2]  = '{1'b0,4'd0,1'b0,  1'b0,4'd0,1'b0,64'h0,      1'b1,1'b0,4'd0,64'h0,1'b0,     16'h0000,1'b0};
    vt[3]  = '{1'b1,4'd15,1'b1, 1'b0,4'd0,1'b0,64'h0,      1'b1,1'b0,4'd0,64'h0,1'b0,     16'h0000,1'b1};
    vt[4]  = '{1'b0,4'd0,1'b0,  1'b1,4'd15,1'b1,64'h55,    1'b1,1'b1,4'd15,64'h55,1'b1,   16'h0000,1'b1};
    vt[5]  = '{1'b0,4'd0,1'b0,  1'b0,4'd0,1'b0,64'h0,      1'b1,1'b0,4'd0,64'h0,1'b0,     16'h0000,1'b0};
    vt[6]  = '{1'b1,4'd5,1'b0,  1'b1,4'd5,1'b0,64'h7,      1'b1,1'b1,4'd5,64'h7,1'b0,     16'h0020,1'b0};
    vt[7]  = '{1'b1,4'd5,1'b0,  1'b0,4'd0,1'b0,64'h0,      1'b1,1'b0,4'd0,64'h0,1'b0,     16'h0020,1'b0};
    vt[8]  = '{1'b0,4'd0,1'b0,  1'b1,4'd5,1'b0,64'h9,      1'b1,1'b1,4'd5,64'h9,1'b0,     16'h0020,1'b0};
    vt[9]  = '{1'b0,4'd0,1'b0,  1'b0,4'd0,1'b0,64'h0,      1'b1,1'b0,4'd0,64'h0,1'b0,     16'h0000,1'b0};
    vt[10] = '{1'b1,4'd15,1'b0, 1'b0,4'd0,1'b0,64'h0,      1'b1,1'b0,4'd0,64'h0,1'b0,     16'h8000,1'b0};
    vt[11] = '{1'b0,4'd0,1'b0,  1'b1,4'd15,1'b0,64'hABCD,  1'b1,1'b1,4'd15,64'hABCD,1'b0, 16'h8000,1'b0};
    vt[12] = '{1'b0,4'd0,1'b0,  1'b0,4'd0,1'b0,64'h0,      1'b1,1'b0,4'd0,64'h0,1'b0,     16'h0000,1'b0};

    idleInputs();
    rst = 1'b1;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    applyStimulus();
    checkOutput("reset alu_ready", 64'(seen_alu_ready), 64'd1);
    checkOutput("reset mem_ready", 64'(seen_mem_ready), 64'd1);
    checkOutput("reset write_en", 64'(write_en), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);

    for (int i = 0; i < 13; i++) begin
      issue_valid = vt[i].iv; issue_addr = vt[i].ia; issue_super = vt[i].is;
      mem_valid = vt[i].mv; mem_addr = vt[i].ma; mem_super = vt[i].ms; mem_data = vt[i].md;
      applyStimulus();
      checkOutput($sformatf("vec%0d mem_ready", i), 64'(seen_mem_ready), 64'(vt[i].e_mr));
      checkOutput($sformatf("vec%0d write_en", i), 64'(write_en), 64'(vt[i].e_we));
      if (vt[i].e_we) begin
        checkOutput($sformatf("vec%0d write_addr", i), 64'(write_addr), 64'(vt[i].e_addr));
        checkOutput($sformatf("vec%0d write_data", i), write_data, vt[i].e_data);
        checkOutput($sformatf("vec%0d supervisor", i), 64'(supervisor), 64'(vt[i].e_sup));
      end
      checkOutput($sformatf("vec%0d busy", i), 64'(busy), 64'(vt[i].e_busy));
      checkOutput($sformatf("vec%0d ssp_busy", i), 64'(ssp_busy), 64'(vt[i].e_ssp));
    end

    // Fill the FIFO while loads keep winning, then hold a fifth result until space frees up.
    idleInputs();
    mem_valid = 1'b1; mem_addr = 4'd1;
    for (int k = 0; k < 4; k++) begin
      alu_valid = 1'b1; alu_addr = 4'(8 + k); alu_data = 64'hA0 + 64'(k); mem_data = 64'h100 + 64'(k);
      applyStimulus();
    end
    alu_addr = 4'd12; alu_data = 64'hA4; mem_data = 64'h104;
    applyStimulus();
    checkOutput("full alu_ready", 64'(seen_alu_ready), 64'd0);
    checkOutput("starved mem_ready", 64'(seen_mem_ready), 64'd0);
    checkOutput("first pop addr", 64'(write_addr), 64'd8);
    checkOutput("first pop data", write_data, 64'hA0);
    mem_data = 64'h105;
    applyStimulus();
    checkOutput("held alu accepted", 64'(seen_alu_ready), 64'd1);
    alu_valid = 1'b0;
    low_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      mem_data = 64'h200 + 64'(k);
      applyStimulus();
      if (!seen_mem_ready) low_cnt++;
    end
    checkOutput("starve pattern pops", 64'(low_cnt), 64'd3);
    idleInputs();
    for (int k = 0; k < 3; k++) applyStimulus();

    // Lone ALU result with the FIFO empty and no load competing.
    alu_valid = 1'b1; alu_addr = 4'd7; alu_data = 64'hAA;
    applyStimulus();
    idleInputs();
`ifdef REG_WRITEBACK_BYPASS_EN
    checkOutput("bypass write_en N+1", 64'(write_en), 64'd1);
    checkOutput("bypass write_addr", 64'(write_addr), 64'd7);
    checkOutput("bypass write_data", write_data, 64'hAA);
    applyStimulus();
    checkOutput("bypass write_en N+2", 64'(write_en), 64'd0);
`else
    checkOutput("alu write_en N+1", 64'(write_en), 64'd0);
    applyStimulus();
    checkOutput("alu write_en N+2", 64'(write_en), 64'd1);
    checkOutput("alu write_addr", 64'(write_addr), 64'd7);
    checkOutput("alu write_data", write_data, 64'hAA);
`endif
    applyStimulus();

    // Randomized traffic with occasional mid-stream resets; stalled payloads are held stable.
    for (int c = 0; c < 700; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        idleInputs();
      end else begin
        rst = 1'b0;
        issue_valid = ($urandom_range(0, 2) == 0);
        issue_addr = rndAddr();
        issue_super = 1'($urandom_range(0, 1));
        if (!(alu_valid && !alu_acc)) begin
          alu_valid = 1'($urandom_range(0, 1));
          alu_addr = rndAddr(); alu_super = 1'($urandom_range(0, 1));
          alu_data = {$urandom, $urandom};
        end
        if (!(mem_valid && !mem_acc)) begin
          mem_valid = 1'($urandom_range(0, 1));
          mem_addr = rndAddr(); mem_super = 1'($urandom_range(0, 1));
          mem_data = {$urandom, $urandom};
        end
      end
      applyStimulus();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
